// File: rtl/ewb_queue_if.sv
// Eviction write buffer bus bundle.
// Groups the cache-side eviction/lookup signals and the memory-side write
// handshake of ewb_queue.
//   slave  : the buffer itself (accepts evictions, drives memory writes)
//   master : the cache/memory environment around the buffer
interface ewb_queue_if #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned LINE_WIDTH = 128,
  parameter int unsigned ADDR_WIDTH = 16
) ();

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  // Cache eviction port
  logic                  evict_valid;
  logic [ADDR_WIDTH-1:0] evict_addr;
  logic [LINE_WIDTH-1:0] evict_wdata;
  logic                  evict_ready;

  // Miss lookup port
  logic [ADDR_WIDTH-1:0] lookup_addr;
  logic                  lookup_hit;
  logic [LINE_WIDTH-1:0] lookup_rdata;

  // Memory write port
  logic                  drain_hold;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [LINE_WIDTH-1:0] mem_wdata;
  logic                  mem_resp;

  // Occupancy
  logic [CW-1:0]         count;
  logic                  full;
  logic                  empty;

  modport slave (
    input  evict_valid, evict_addr, evict_wdata, lookup_addr, drain_hold, mem_resp,
    output evict_ready, lookup_hit, lookup_rdata, mem_write, mem_addr, mem_wdata,
           count, full, empty
  );

  modport master (
    output evict_valid, evict_addr, evict_wdata, lookup_addr, drain_hold, mem_resp,
    input  evict_ready, lookup_hit, lookup_rdata, mem_write, mem_addr, mem_wdata,
           count, full, empty
  );

endinterface

// File: rtl/ewb_queue.sv
// Multi-entry eviction write buffer between cache controller and memory.
// Evicted dirty lines are queued in a circular buffer and drained to memory
// one at a time; queued lines serve cache misses; a repeat eviction of a
// queued line overwrites that entry instead of taking a new slot.
// Ports:
//   clk   : single clock, rising edge
//   reset : asynchronous, active-high, clears all state
//   bus   : ewb_queue_if.slave (eviction, lookup, memory write, occupancy)
module ewb_queue #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned LINE_WIDTH  = 128,
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned OFFSET_BITS = 4
) (
  input  logic        clk,
  input  logic        reset,
  ewb_queue_if.slave  bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned TW = ADDR_WIDTH - OFFSET_BITS;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t                state_q;
  state_t                state_d;

  logic [TW-1:0]         tag_q  [DEPTH];
  logic [LINE_WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]      valid_q;
  logic [PW-1:0]         head_q;
  logic [PW-1:0]         tail_q;
  logic [CW-1:0]         count_q;

  logic [TW-1:0]         evict_tag;
  logic [TW-1:0]         lookup_tag;
  logic                  full_c;
  logic                  empty_c;
  logic                  coal_hit;
  logic [PW-1:0]         coal_idx;
  logic                  ready_c;
  logic                  accept;
  logic                  alloc;
  logic                  pop;
  logic                  mem_write_c;
  logic                  look_hit;
  logic [LINE_WIDTH-1:0] look_data;
  logic [PW-1:0]         scan_idx;
  logic [ADDR_WIDTH-1:0] mem_addr_c;
  logic                  unused_addr_bits;

  assign evict_tag  = bus.evict_addr[ADDR_WIDTH-1:OFFSET_BITS];
  assign lookup_tag = bus.lookup_addr[ADDR_WIDTH-1:OFFSET_BITS];

  // Offset bits only take part in the line address, never in matching
  assign unused_addr_bits = ^{bus.evict_addr, bus.lookup_addr};

  assign full_c  = (count_q == CW'(DEPTH));
  assign empty_c = (count_q == '0);

  // Coalesce target: matching valid entry, excluding the head while it is
  // being written to memory (its data is already committed to the bus)
  always_comb begin
    coal_hit = 1'b0;
    coal_idx = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (valid_q[i] && (tag_q[i] == evict_tag) &&
          !((state_q == WRITE) && (PW'(i) == head_q))) begin
        coal_hit = 1'b1;
        coal_idx = PW'(i);
      end
    end
  end

  assign ready_c = coal_hit || !full_c;
  assign accept  = bus.evict_valid && ready_c;
  assign alloc   = accept && !coal_hit;
  assign pop     = (state_q == WRITE) && bus.mem_resp;

  // Lookup: walk from oldest to youngest so the youngest match wins
  always_comb begin
    look_hit  = 1'b0;
    look_data = '0;
    scan_idx  = head_q;
    for (int k = 0; k < int'(DEPTH); k++) begin
      scan_idx = head_q + PW'(k);
      if (valid_q[scan_idx] && (tag_q[scan_idx] == lookup_tag)) begin
        look_hit  = 1'b1;
        look_data = data_q[scan_idx];
      end
    end
  end

  // Pointers, occupancy and valid flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PW'(1);
      end
      if (alloc) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PW'(1);
      end
      count_q <= count_q + CW'(alloc) - CW'(pop);
    end
  end

  // Entry storage; contents are don't-care until marked valid
  always_ff @(posedge clk) begin
    if (accept) begin
      if (coal_hit) begin
        data_q[coal_idx] <= bus.evict_wdata;
      end else begin
        data_q[tail_q] <= bus.evict_wdata;
        tag_q[tail_q]  <= evict_tag;
      end
    end
  end

  // Drain FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Drain FSM next state; an accept into an empty buffer starts the write
  // on the same edge so mem_write follows the accept by one cycle
  always_comb begin
    state_d     = state_q;
    mem_write_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (!bus.drain_hold && (!empty_c || accept)) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        mem_write_c = 1'b1;
        if (bus.mem_resp) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Head line address with the offset field cleared
  always_comb begin
    mem_addr_c                              = '0;
    mem_addr_c[ADDR_WIDTH-1:OFFSET_BITS]    = tag_q[head_q];
  end

  assign bus.evict_ready  = ready_c;
  assign bus.lookup_hit   = look_hit;
  assign bus.lookup_rdata = look_data;
  assign bus.mem_write    = mem_write_c;
  assign bus.mem_addr     = mem_addr_c;
  assign bus.mem_wdata    = data_q[head_q];
  assign bus.count        = count_q;
  assign bus.full         = full_c;
  assign bus.empty        = empty_c;

endmodule

// File: tb/tb_ewb_queue.sv
// Directed bench for ewb_queue: a per-cycle vector table for the normal
// flow, then a hand-written sequence for reset during a memory write.
module tb_ewb_queue;

  localparam int unsigned DEPTH       = 4;
  localparam int unsigned LINE_WIDTH  = 128;
  localparam int unsigned ADDR_WIDTH  = 16;
  localparam int unsigned OFFSET_BITS = 4;

  logic clk;
  logic reset;

  ewb_queue_if #(.DEPTH(DEPTH), .LINE_WIDTH(LINE_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

  ewb_queue #(
    .DEPTH(DEPTH), .LINE_WIDTH(LINE_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH), .OFFSET_BITS(OFFSET_BITS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         ev;
    logic [15:0]  ea;
    logic [127:0] ed;
    logic [15:0]  la;
    logic         hold;
    logic         resp;
    logic         rdy;
    logic         hit;
    logic [127:0] rd;
    logic         mw;
    logic [15:0]  ma;
    logic [127:0] md;
    logic [2:0]   cnt;
  } vec_t;

  localparam logic [127:0] Z  = 128'h0;
  localparam logic [127:0] DA = {4{32'hA0A0_0001}};
  localparam logic [127:0] D1 = {4{32'h1111_0001}};
  localparam logic [127:0] D2 = {4{32'h2222_0002}};
  localparam logic [127:0] D3 = {4{32'h3333_0003}};
  localparam logic [127:0] D4 = {4{32'h4444_0004}};
  localparam logic [127:0] D5 = {4{32'h5555_0005}};
  localparam logic [127:0] DB = {4{32'hBBBB_000B}};
  localparam logic [127:0] DC = {4{32'hCCCC_000C}};
  localparam logic [127:0] DE = {4{32'hEEEE_000E}};
  localparam logic [127:0] D7 = {4{32'h7777_0007}};
  localparam logic [127:0] D8 = {4{32'h8888_0008}};
  localparam logic [127:0] D9 = {4{32'h9999_0009}};
  localparam logic [127:0] DX = {4{32'hA00C_00AA}};
  localparam logic [15:0]  XA = 16'hF000;

  int   checks;
  int   errors;
  int   row;
  vec_t vecs[$];

  function automatic vec_t v(logic ev, logic [15:0] ea, logic [127:0] ed, logic [15:0] la,
                             logic hold, logic resp, logic rdy, logic hit, logic [127:0] rd,
                             logic mw, logic [15:0] ma, logic [127:0] md, logic [2:0] cnt);
    vec_t r;
    r.ev = ev; r.ea = ea; r.ed = ed; r.la = la; r.hold = hold; r.resp = resp;
    r.rdy = rdy; r.hit = hit; r.rd = rd; r.mw = mw; r.ma = ma; r.md = md; r.cnt = cnt;
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (row %0d): got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic chk_count(input logic [2:0] cnt);
    chk("count", 128'(bus.count), 128'(cnt));
    chk("full",  128'(bus.full),  128'(cnt == 3'd4));
    chk("empty", 128'(bus.empty), 128'(cnt == 3'd0));
  endtask

  task automatic drive(input logic ev, input logic [15:0] ea, input logic [127:0] ed,
                       input logic [15:0] la, input logic hold, input logic resp);
    bus.evict_valid = ev;
    bus.evict_addr  = ea;
    bus.evict_wdata = ed;
    bus.lookup_addr = la;
    bus.drain_hold  = hold;
    bus.mem_resp    = resp;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    row    = 0;
    reset  = 1'b1;
    drive(1'b0, XA, Z, 16'h0000, 1'b0, 1'b0);

    //     ev  ea        ed  la        hd   rsp  | rdy hit rd  mw  ma        md  cnt
    vecs.push_back(v(0, XA,      Z,  16'h1230, 0, 0,  1, 0, Z,  0, 16'h0000, Z,  0));
    vecs.push_back(v(1, 16'h1230, DA, 16'h1230, 0, 0,  1, 0, Z,  0, 16'h0000, Z,  0));
    vecs.push_back(v(0, XA,      Z,  16'h1230, 0, 0,  1, 1, DA, 1, 16'h1230, DA, 1));
    vecs.push_back(v(0, XA,      Z,  16'h1230, 0, 0,  1, 1, DA, 1, 16'h1230, DA, 1));
    vecs.push_back(v(0, XA,      Z,  16'h1230, 0, 1,  1, 1, DA, 1, 16'h1230, DA, 1));
    vecs.push_back(v(0, XA,      Z,  16'h1230, 0, 0,  1, 0, Z,  0, 16'h0000, Z,  0));
    vecs.push_back(v(1, 16'h1000, D1, 16'h1000, 1, 0,  1, 0, Z,  0, 16'h0000, Z,  0));
    vecs.push_back(v(1, 16'h2000, D2, 16'h1000, 1, 0,  1, 1, D1, 0, 16'h0000, Z,  1));
    vecs.push_back(v(1, 16'h3000, D3, 16'h2000, 1, 0,  1, 1, D2, 0, 16'h0000, Z,  2));
    vecs.push_back(v(1, 16'h4000, D4, 16'h3000, 1, 0,  1, 1, D3, 0, 16'h0000, Z,  3));
    vecs.push_back(v(1, 16'h5000, D5, 16'h3000, 1, 0,  0, 1, D3, 0, 16'h0000, Z,  4));
    vecs.push_back(v(1, 16'h2004, DB, 16'h2000, 1, 0,  1, 1, D2, 0, 16'h0000, Z,  4));
    vecs.push_back(v(0, XA,      Z,  16'h2000, 1, 0,  0, 1, DB, 0, 16'h0000, Z,  4));
    vecs.push_back(v(0, XA,      Z,  16'h1000, 0, 0,  0, 1, D1, 0, 16'h0000, Z,  4));
    vecs.push_back(v(0, XA,      Z,  16'h1000, 0, 0,  0, 1, D1, 1, 16'h1000, D1, 4));
    vecs.push_back(v(0, XA,      Z,  16'h1000, 0, 1,  0, 1, D1, 1, 16'h1000, D1, 4));
    vecs.push_back(v(0, XA,      Z,  16'h1000, 0, 0,  1, 0, Z,  0, 16'h0000, Z,  3));
    vecs.push_back(v(1, 16'h2000, DC, 16'h2000, 0, 0,  1, 1, DB, 1, 16'h2000, DB, 3));
    vecs.push_back(v(1, 16'h2000, DE, 16'h2000, 0, 0,  1, 1, DC, 1, 16'h2000, DB, 4));
    vecs.push_back(v(0, XA,      Z,  16'h2000, 0, 1,  0, 1, DE, 1, 16'h2000, DB, 4));
    vecs.push_back(v(0, XA,      Z,  16'h2000, 0, 0,  1, 1, DE, 0, 16'h0000, Z,  3));
    vecs.push_back(v(0, XA,      Z,  16'h4000, 0, 1,  1, 1, D4, 1, 16'h3000, D3, 3));
    vecs.push_back(v(0, XA,      Z,  16'h4000, 0, 0,  1, 1, D4, 0, 16'h0000, Z,  2));
    vecs.push_back(v(0, XA,      Z,  16'h4000, 0, 1,  1, 1, D4, 1, 16'h4000, D4, 2));
    vecs.push_back(v(0, XA,      Z,  16'h4000, 0, 0,  1, 0, Z,  0, 16'h0000, Z,  1));
    vecs.push_back(v(0, XA,      Z,  16'h2000, 0, 1,  1, 1, DE, 1, 16'h2000, DE, 1));
    vecs.push_back(v(0, XA,      Z,  16'h2000, 0, 0,  1, 0, Z,  0, 16'h0000, Z,  0));
    vecs.push_back(v(1, 16'h7004, D7, 16'h7000, 1, 0,  1, 0, Z,  0, 16'h0000, Z,  0));
    vecs.push_back(v(0, XA,      Z,  16'h7008, 1, 0,  1, 1, D7, 0, 16'h0000, Z,  1));

    // Reset state, sampled while reset is held
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_write", 128'(bus.mem_write), 128'(1'b0));
    chk("rst_ready",     128'(bus.evict_ready), 128'(1'b1));
    chk("rst_hit",       128'(bus.lookup_hit), 128'(1'b0));
    chk("rst_rdata",     bus.lookup_rdata, Z);
    chk_count(3'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      row = i;
      drive(vecs[i].ev, vecs[i].ea, vecs[i].ed, vecs[i].la, vecs[i].hold, vecs[i].resp);
      @(negedge clk);
      chk("evict_ready",  128'(bus.evict_ready), 128'(vecs[i].rdy));
      chk("lookup_hit",   128'(bus.lookup_hit),  128'(vecs[i].hit));
      chk("lookup_rdata", bus.lookup_rdata,      vecs[i].rd);
      chk("mem_write",    128'(bus.mem_write),   128'(vecs[i].mw));
      if (vecs[i].mw) begin
        chk("mem_addr",  128'(bus.mem_addr), 128'(vecs[i].ma));
        chk("mem_wdata", bus.mem_wdata,      vecs[i].md);
      end
      chk_count(vecs[i].cnt);
      @(posedge clk);
      #1;
    end

    // Reset in the middle of a memory write with three queued lines
    row = 100;
    drive(1'b1, 16'h8000, D8, 16'h7000, 1'b1, 1'b0);
    @(negedge clk);
    chk_count(3'd1);
    @(posedge clk); #1;
    row = 101;
    drive(1'b1, 16'h9000, D9, 16'h7000, 1'b1, 1'b0);
    @(negedge clk);
    chk_count(3'd2);
    @(posedge clk); #1;
    row = 102;
    drive(1'b0, XA, Z, 16'h7000, 1'b0, 1'b0);
    @(negedge clk);
    chk("mem_write", 128'(bus.mem_write), 128'(1'b0));
    chk_count(3'd3);
    @(posedge clk); #1;
    row = 103;
    @(negedge clk);
    chk("mem_write", 128'(bus.mem_write), 128'(1'b1));
    chk("mem_addr",  128'(bus.mem_addr),  128'(16'h7000));
    chk("mem_wdata", bus.mem_wdata, D7);
    reset = 1'b1;
    #1;
    row = 104;
    chk("async_mem_write", 128'(bus.mem_write), 128'(1'b0));
    chk("async_hit",       128'(bus.lookup_hit), 128'(1'b0));
    chk("async_rdata",     bus.lookup_rdata, Z);
    chk("async_ready",     128'(bus.evict_ready), 128'(1'b1));
    chk_count(3'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Normal drain after reset
    row = 105;
    drive(1'b1, 16'hA00C, DX, 16'hA000, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, XA, Z, 16'hA000, 1'b0, 1'b1);
    @(negedge clk);
    chk("mem_write", 128'(bus.mem_write), 128'(1'b1));
    chk("mem_addr",  128'(bus.mem_addr),  128'(16'hA000));
    chk("mem_wdata", bus.mem_wdata, DX);
    chk("lookup_hit", 128'(bus.lookup_hit), 128'(1'b1));
    chk_count(3'd1);
    @(posedge clk); #1;
    row = 106;
    drive(1'b0, XA, Z, 16'hA000, 1'b0, 1'b0);
    @(negedge clk);
    chk("mem_write",  128'(bus.mem_write), 128'(1'b0));
    chk("lookup_hit", 128'(bus.lookup_hit), 128'(1'b0));
    chk_count(3'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ewb_queue.md
# ewb_queue

Parametrised multi-entry eviction write buffer placed between the cache controller and the memory port. Dirty lines evicted by the cache are queued with their line addresses and drained to memory one at a time over a write/response handshake. While a line is queued, a cache miss to that line is served from the buffer. A second eviction to an already-queued line updates that entry in place instead of taking a new slot.

## Interface
- DEPTH, 4: number of entries; power of two, ≥2.
- LINE_WIDTH, 128: line data bits.
- ADDR_WIDTH, 16: address bits.
- OFFSET_BITS, 4: low address bits ignored for matching and zeroed on mem_addr.

- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- evict_valid  in  1  cache presents an evicted line.
- evict_addr  in  ADDR_WIDTH  address of evicted line.
- evict_wdata  in  LINE_WIDTH  evicted line data.
- evict_ready  out  1  entry accepted on this edge if evict_valid=1.
- lookup_addr  in  ADDR_WIDTH  miss address to search.
- lookup_hit  out  1  combinational; a valid entry matches lookup_addr.
- lookup_rdata  out  LINE_WIDTH  data of youngest matching entry; 0 when no hit.
- drain_hold  in  1  blocks the start of a new memory write; the memory port is in use for reads.
- mem_write  out  1  write request to memory.
- mem_addr  out  ADDR_WIDTH  head entry address, offset bits forced to 0.
- mem_wdata  out  LINE_WIDTH  head entry data.
- mem_resp  in  1  memory completed the write.
- count  out  $clog2(DEPTH)+1  valid entries.
- full, empty  out  1  count==DEPTH, count==0.

## Operation
- Circular storage: head pointer (oldest entry), tail pointer (next free slot), count. Both pointers wrap modulo DEPTH.
- Match is defined as addr[ADDR_WIDTH-1:OFFSET_BITS] equal to a valid entry's tag.
- Coalesce target: a valid entry that matches evict_addr and is not the head while state=WRITE. At most one coalesce target exists.
- evict_ready = coalesce_target_exists OR !full.
- Accepted eviction with a coalesce target: overwrite that entry's data. No pointer or count change.
- Accepted eviction without a coalesce target: write the entry at tail, then tail+1, count+1.
- Lookup scans all valid entries and returns the youngest match. At most two entries can match: the in-flight head and one younger entry.
- Drain FSM, states IDLE and WRITE:
  - IDLE -> WRITE when !empty and !drain_hold. mem_write=0 in IDLE.
  - In WRITE, mem_write=1 and mem_addr/mem_wdata hold the head entry, stable until mem_resp. drain_hold has no effect once in WRITE.
  - WRITE with mem_resp: head+1, count-1, next state IDLE.
- Same-edge accept and pop: count is unchanged and both pointers advance.
- Reset values: state IDLE, head=tail=0, count=0, empty=1, full=0, evict_ready=1, mem_write=0, lookup_hit=0, lookup_rdata=0. Entry data is don't-care.
- Reset asserted during WRITE: mem_write drops asynchronously and the queued lines are discarded.

## Timing
- Accept to lookup visibility: 1 cycle. A lookup in the same cycle as the accept sees the old contents; there is no bypass.
- Coalesced data is visible to lookup on the next cycle.
- Accept to mem_write: earliest 1 cycle, when starting from IDLE and empty with drain_hold=0.
- A popped entry still hits lookup during the mem_resp cycle and stops hitting after that edge.
- Back-to-back drains: one IDLE cycle between consecutive mem_write pulses.
- evict_ready does not rise in the same cycle as a pop from full. It depends on registered count plus the combinational coalesce check.

## Test plan
- Reset, then evict 0x1230 with data A; mem_resp after 3 cycles -> mem_write rises 1 cycle after accept, mem_addr=0x1230, mem_wdata=A; count goes 1 -> 0; empty=1.
- drain_hold=1 while filling 4 lines 0x1000/0x2000/0x3000/0x4000 -> full=1, evict_ready=0 for new address 0x5000. Release hold -> drains in FIFO order with one idle cycle between writes; pointers wrap.
- Buffer full, evict 0x2004 with new data B -> evict_ready=1 via coalesce; count stays 4; lookup 0x2000 returns B next cycle.
- Head 0x1000 in WRITE, evict 0x1000 with data C -> new entry allocated, count+1. Lookup 0x1000 returns C. mem_wdata still holds the old head data until mem_resp.
- Lookup miss on address 0x7000 -> lookup_hit=0, lookup_rdata=0. Lookup in the same cycle as the accept of 0x7000 -> miss; next cycle -> hit.
- Assert reset mid-WRITE with 3 entries -> mem_write=0 immediately; count=0, empty=1; subsequent eviction drains normally.
